// File: rtl/id_ex_stage_pkg.sv
// Shared constants and types for the ID/EX stage: ALU op codes, widths, forward selects.
package id_ex_stage_pkg;
  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;
endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side, forwarding-side and ALU-side signals of the ID/EX stage.
interface id_ex_stage_if
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) ();
  logic                 stall, flush;
  logic                 id_valid;
  logic [DW-1:0]        id_rs_data, id_rt_data;
  logic [15:0]          id_imm;
  logic [4:0]           id_shamt;
  logic [RW-1:0]        id_rs, id_rt, id_rd;
  logic [3:0]           id_alu_op;
  logic                 id_alu_src, id_reg_dst, id_reg_write;
  logic                 id_mem_read, id_mem_write, id_mem_to_reg;
  logic                 exmem_reg_write;
  logic [RW-1:0]        exmem_rd;
  logic [DW-1:0]        exmem_result;
  logic                 memwb_reg_write;
  logic [RW-1:0]        memwb_rd;
  logic [DW-1:0]        memwb_result;
  logic                 ex_valid;
  logic signed [DW-1:0] alu_operand1, alu_operand2;
  logic [3:0]           alu_control;
  logic [4:0]           alu_shamt;
  logic [DW-1:0]        ex_store_data;
  logic [RW-1:0]        ex_wr_reg;
  logic                 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic                 load_use_hazard;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, alu_operand1, alu_operand2, alu_control, alu_shamt,
           ex_store_data, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use_hazard
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm, id_shamt,
           id_rs, id_rt, id_rd, id_alu_op, id_alu_src, id_reg_dst, id_reg_write,
           id_mem_read, id_mem_write, id_mem_to_reg,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, alu_operand1, alu_operand2, alu_control, alu_shamt,
           ex_store_data, ex_wr_reg, ex_reg_write, ex_mem_read, ex_mem_write,
           ex_mem_to_reg, load_use_hazard
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand's forwarding select and value. Forwarding exists only with EX_FORWARD_EN defined;
// otherwise the registered register-file value passes straight through.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_val,
  input  logic          exmem_we,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_res,
  input  logic          memwb_we,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_res,
  output logic [1:0]    sel,
  output logic [DW-1:0] val
);
`ifdef EX_FORWARD_EN
  // EX/MEM is the younger producer, so it is checked first; r0 never forwards.
  always_comb begin
    sel = FWD_REG;
    if (exmem_we && exmem_rd != '0 && exmem_rd == idx)      sel = FWD_MEM;
    else if (memwb_we && memwb_rd != '0 && memwb_rd == idx) sel = FWD_WB;
  end

  always_comb begin
    case (sel)
      FWD_MEM: val = exmem_res;
      FWD_WB:  val = memwb_res;
      default: val = reg_val;
    endcase
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{idx, exmem_we, exmem_rd, exmem_res, memwb_we, memwb_rd, memwb_res};
  assign sel = FWD_REG;
  assign val = reg_val;
`endif
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register plus EX operand select feeding the ALU, with load-use detection.
// Optional macro EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input logic         clk,
  input logic         reset,
  id_ex_stage_if.slave bus
);
  logic          ex_vld;
  ctrl_t         ex_ctrl;
  logic [RW-1:0] rs_q, rt_q, wr_q;
  logic [DW-1:0] rsd_q, rtd_q, imm_q;
  logic          src_q;
  logic [3:0]    op_q;
  logic [4:0]    sh_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_vld  <= 1'b0;
      ex_ctrl <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      wr_q    <= '0;
      rsd_q   <= '0;
      rtd_q   <= '0;
      imm_q   <= '0;
      src_q   <= 1'b0;
      op_q    <= ALU_ADD;
      sh_q    <= '0;
    end else if (bus.flush) begin
      // Bubble: data fields are don't-care once valid and controls drop.
      ex_vld  <= 1'b0;
      ex_ctrl <= '0;
    end else if (!bus.stall) begin
      ex_vld  <= bus.id_valid;
      ex_ctrl <= bus.id_valid ? ctrl_t'{bus.id_reg_write, bus.id_mem_read,
                                        bus.id_mem_write, bus.id_mem_to_reg} : '0;
      rs_q    <= bus.id_rs;
      rt_q    <= bus.id_rt;
      wr_q    <= bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      rsd_q   <= bus.id_rs_data;
      rtd_q   <= bus.id_rt_data;
      imm_q   <= {{(DW-16){bus.id_imm[15]}}, bus.id_imm};
      src_q   <= bus.id_alu_src;
      op_q    <= bus.id_alu_op;
      sh_q    <= bus.id_shamt;
    end
  end

  // Operand 0 is rs, operand 1 is rt.
  logic [1:0][RW-1:0] src_idx;
  logic [1:0][DW-1:0] reg_val, fwd_val;
  logic [1:0][1:0]    fwd_sel;

  assign src_idx = {rt_q, rs_q};
  assign reg_val = {rtd_q, rsd_q};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    fwd_mux #(.DW(DW), .RW(RW)) u_fwd (
      .idx       (src_idx[i]),
      .reg_val   (reg_val[i]),
      .exmem_we  (bus.exmem_reg_write),
      .exmem_rd  (bus.exmem_rd),
      .exmem_res (bus.exmem_result),
      .memwb_we  (bus.memwb_reg_write),
      .memwb_rd  (bus.memwb_rd),
      .memwb_res (bus.memwb_result),
      .sel       (fwd_sel[i]),
      .val       (fwd_val[i])
    );
  end

  logic unused_sel;
  assign unused_sel = ^fwd_sel;

  assign bus.ex_valid      = ex_vld;
  assign bus.alu_operand1  = fwd_val[0];
  assign bus.alu_operand2  = src_q ? imm_q : fwd_val[1];
  assign bus.ex_store_data = fwd_val[1];
  assign bus.alu_control   = op_q;
  assign bus.alu_shamt     = sh_q;
  assign bus.ex_wr_reg     = wr_q;
  assign bus.ex_reg_write  = ex_ctrl.reg_write;
  assign bus.ex_mem_read   = ex_ctrl.mem_read;
  assign bus.ex_mem_write  = ex_ctrl.mem_write;
  assign bus.ex_mem_to_reg = ex_ctrl.mem_to_reg;

  // Compares against the live ID indices, not the registered ones.
  assign bus.load_use_hazard = ex_vld & ex_ctrl.mem_read & (wr_q != '0) &
                               ((wr_q == bus.id_rs) | (wr_q == bus.id_rt));
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios, then random traffic checked by a queue scoreboard.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  id_ex_stage_if bus ();
  id_ex_stage dut (.clk(clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit sb_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    bit v;
    logic [4:0] rs, rt, wr, sh;
    logic [31:0] rsd, rtd, imm;
    bit src;
    logic [3:0] op;
    bit rw, mr, mw, m2r;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  exp_t m;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] v);
    if (idx == 5'd0) return v;
`ifdef EX_FORWARD_EN
    if (bus.exmem_reg_write && bus.exmem_rd == idx) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == idx) return bus.memwb_result;
`endif
    return v;
  endfunction

  function automatic logic [31:0] sext(logic [15:0] i);
    return i[15] ? 32'(i) - 32'h10000 : 32'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(bit v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                     logic [31:0] rsd, logic [31:0] rtd, logic [15:0] imm,
                     logic [3:0] op, bit src, bit dst, bit rw, bit mr);
    bus.id_valid = v;      bus.id_rs = rs;        bus.id_rt = rt;     bus.id_rd = rd;
    bus.id_rs_data = rsd;  bus.id_rt_data = rtd;  bus.id_imm = imm;   bus.id_alu_op = op;
    bus.id_alu_src = src;  bus.id_reg_dst = dst;  bus.id_reg_write = rw;
    bus.id_mem_read = mr;  bus.id_mem_write = 1'b0; bus.id_mem_to_reg = mr;
    bus.id_shamt = rd;
  endtask

  // Expected EX view for whatever is driven now; it becomes visible after the next edge.
  task automatic rand_step();
    exp_t e;
    tick();
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.stall = ($urandom_range(0, 6) == 0);
    bus.id_valid = ($urandom_range(0, 4) != 0);
    bus.id_rs_data = $urandom;  bus.id_rt_data = $urandom;
    bus.id_imm = 16'($urandom); bus.id_shamt = 5'($urandom);
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rd = 5'($urandom_range(0, 3)); bus.id_alu_op = 4'($urandom_range(0, 3));
    bus.id_alu_src = 1'($urandom);   bus.id_reg_dst = 1'($urandom);
    bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
    bus.id_mem_write = 1'($urandom); bus.id_mem_to_reg = 1'($urandom);
    bus.exmem_reg_write = 1'($urandom); bus.exmem_rd = 5'($urandom_range(0, 3));
    bus.exmem_result = $urandom;
    bus.memwb_reg_write = 1'($urandom); bus.memwb_rd = 5'($urandom_range(0, 3));
    bus.memwb_result = $urandom;
    if (bus.flush) begin
      e = cur;
      e.v = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.m2r = 0;
    end else if (bus.stall) begin
      e = cur;
    end else begin
      e.v = bus.id_valid;
      e.rs = bus.id_rs;  e.rt = bus.id_rt;  e.rsd = bus.id_rs_data;  e.rtd = bus.id_rt_data;
      e.wr = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
      e.imm = sext(bus.id_imm); e.src = bus.id_alu_src;
      e.op = bus.id_alu_op;     e.sh = bus.id_shamt;
      e.rw  = bus.id_valid && bus.id_reg_write;
      e.mr  = bus.id_valid && bus.id_mem_read;
      e.mw  = bus.id_valid && bus.id_mem_write;
      e.m2r = bus.id_valid && bus.id_mem_to_reg;
    end
    e.cyc = cyc;
    q.push_back(e);
    cur = e;
  endtask

  always @(negedge clk) begin
    if (sb_on && q.size() > 0 && q[0].cyc < cyc) begin
      m = q.pop_front();
      chk("sb_valid", 32'(bus.ex_valid), 32'(m.v));
      chk("sb_ctrl", {28'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg},
          {28'd0, m.rw, m.mr, m.mw, m.m2r});
      chk("sb_hazard", 32'(bus.load_use_hazard),
          32'(m.v && m.mr && m.wr != 0 && (m.wr == bus.id_rs || m.wr == bus.id_rt)));
      if (m.v) begin
        chk("sb_op1", bus.alu_operand1, fwd(m.rs, m.rsd));
        chk("sb_op2", bus.alu_operand2, m.src ? m.imm : fwd(m.rt, m.rtd));
        chk("sb_store", bus.ex_store_data, fwd(m.rt, m.rtd));
        chk("sb_aluctl", 32'(bus.alu_control), 32'(m.op));
        chk("sb_shamt", 32'(bus.alu_shamt), 32'(m.sh));
        chk("sb_wrreg", 32'(bus.ex_wr_reg), 32'(m.wr));
      end
    end
  end

  initial begin
    bus.stall = 0; bus.flush = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.exmem_reg_write = 0; bus.exmem_rd = 0; bus.exmem_result = 0;
    bus.memwb_reg_write = 0; bus.memwb_rd = 0; bus.memwb_result = 0;
    #12;
    chk("rst_valid", 32'(bus.ex_valid), 0);
    chk("rst_aluctl", 32'(bus.alu_control), 0);
    chk("rst_op1", bus.alu_operand1, 0);
    chk("rst_op2", bus.alu_operand2, 0);
    chk("rst_wrreg", 32'(bus.ex_wr_reg), 0);
    chk("rst_regwrite", 32'(bus.ex_reg_write), 0);
    @(negedge clk) reset = 1'b1;

    // SUB 5,3 with no forwarding match
    drv(1, 1, 2, 3, 5, 3, 16'h0, ALU_SUB, 0, 1, 1, 0);
    tick();
    chk("sub_valid", 32'(bus.ex_valid), 1);
    chk("sub_op1", bus.alu_operand1, 5);
    chk("sub_op2", bus.alu_operand2, 3);
    chk("sub_aluctl", 32'(bus.alu_control), 32'(ALU_SUB));
    chk("sub_wrreg", 32'(bus.ex_wr_reg), 3);

    drv(1, 1, 2, 3, 5, 3, 16'hFFFE, ALU_ADD, 1, 1, 1, 0);
    tick();
    chk("imm_op2", bus.alu_operand2, 32'hFFFF_FFFE);
    chk("imm_store", bus.ex_store_data, 3);

    // Forward priority on rs=8: EX/MEM over MEM/WB over register value
    drv(1, 8, 2, 3, 7, 3, 16'h0, ALU_ADD, 0, 1, 1, 0);
    bus.exmem_reg_write = 1; bus.exmem_rd = 8; bus.exmem_result = 100;
    bus.memwb_reg_write = 1; bus.memwb_rd = 8; bus.memwb_result = 200;
    tick();
`ifdef EX_FORWARD_EN
    chk("fwd_mem", bus.alu_operand1, 100);
    bus.exmem_rd = 0; #1;
    chk("fwd_wb", bus.alu_operand1, 200);
`else
    chk("nofwd_mem", bus.alu_operand1, 7);
    bus.exmem_rd = 0; #1;
    chk("nofwd_wb", bus.alu_operand1, 7);
`endif
    bus.memwb_rd = 0; #1;
    chk("fwd_reg", bus.alu_operand1, 7);
    bus.exmem_reg_write = 0; bus.memwb_reg_write = 0;

    // lw into r9, then a dependent instruction in ID
    drv(1, 1, 9, 0, 0, 0, 16'h4, ALU_ADD, 1, 0, 1, 1);
    tick();
    chk("lw_wrreg", 32'(bus.ex_wr_reg), 9);
    drv(1, 4, 5, 6, 0, 0, 16'h0, ALU_ADD, 0, 1, 1, 0); #1;
    chk("hz_none", 32'(bus.load_use_hazard), 0);
    drv(1, 4, 9, 6, 0, 0, 16'h0, ALU_ADD, 0, 1, 1, 0); #1;
    chk("hz_rt", 32'(bus.load_use_hazard), 1);
    bus.flush = 1;
    tick();
    bus.flush = 0;
    chk("hz_flush_valid", 32'(bus.ex_valid), 0);
    chk("hz_flush_hz", 32'(bus.load_use_hazard), 0);
    chk("hz_flush_rw", 32'(bus.ex_reg_write), 0);

    // Stall holds across changing ID inputs
    drv(1, 2, 3, 6, 32'h11, 32'h22, 16'h0, ALU_AND, 0, 1, 1, 0);
    tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)),
          $urandom, $urandom, 16'($urandom), ALU_OR, 1, 0, 1, 1);
      tick();
      chk("stall_op1", bus.alu_operand1, 32'h11);
      chk("stall_op2", bus.alu_operand2, 32'h22);
      chk("stall_aluctl", 32'(bus.alu_control), 32'(ALU_AND));
      chk("stall_wrreg", 32'(bus.ex_wr_reg), 6);
    end
    bus.flush = 1;
    tick();
    chk("sf_valid", 32'(bus.ex_valid), 0);
    chk("sf_rw", 32'(bus.ex_reg_write), 0);
    chk("sf_mr", 32'(bus.ex_mem_read), 0);
    bus.flush = 0; bus.stall = 0;

    // Asynchronous reset while stalled
    drv(1, 1, 2, 3, 1, 2, 16'h0, ALU_OR, 0, 1, 1, 0);
    tick();
    chk("pre_rst_valid", 32'(bus.ex_valid), 1);
    bus.stall = 1;
    #3 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 0);
    chk("arst_rw", 32'(bus.ex_reg_write), 0);
    chk("arst_aluctl", 32'(bus.alu_control), 0);
    @(negedge clk);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.stall = 0;
    reset = 1'b1;

    // Random traffic against the scoreboard
    cur = '{cyc: 0, v: 0, rs: 0, rt: 0, wr: 0, sh: 0, rsd: 0, rtd: 0, imm: 0,
            src: 0, op: 0, rw: 0, mr: 0, mw: 0, m2r: 0};
    sb_on = 1'b1;
    for (int n = 0; n < 400; n++) rand_step();
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 32'(q.size()), 0);
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX operand-select stage; sits directly upstream of the 32-bit ALU.
- Captures decoded operands and control from ID, applies EX/MEM and MEM/WB forwarding, and drives the ALU with Operand1, Operand2, ALUControl and shiftAmount.
- Also detects load-use hazards so the hazard logic can stall IF/ID.

Parameters:
- DW, 32, datapath width
- RW, 5, register-index width

Ports:
- clk  in  1  single clock for the block
- reset  in  1  asynchronous, active-low reset; clears every stage register
- stall  in  1  hold the current EX contents
- flush  in  1  insert a bubble into EX
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  16  raw immediate
- id_shamt  in  5  shift amount
- id_rs, id_rt, id_rd  in  RW  register indices
- id_alu_op  in  4  ALU control code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decoded controls
- exmem_reg_write  in  1  EX/MEM stage writes a register
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM result
- memwb_reg_write  in  1  MEM/WB stage writes a register
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB result
- ex_valid  out  1  EX holds a real instruction
- alu_operand1, alu_operand2  out  DW  signed ALU operands
- alu_control  out  4  to ALUControl
- alu_shamt  out  5  to shiftAmount
- ex_store_data  out  DW  forwarded rt value, for stores
- ex_wr_reg  out  RW  destination: rd if reg_dst=1, else rt
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  controls passed downstream
- load_use_hazard  out  1  combinational stall request to the hazard unit

Behaviour:
- Reset (reset=0, asynchronous): all registered state goes to 0.
  - ex_valid=0, all control outputs 0, alu_control=0000, ex_wr_reg=0, stored data=0.
  - Operand outputs therefore read 0 while no forwarding matches.
- Rising clk, priority order flush > stall > load.
  - flush=1: ex_valid=0 and all write/mem controls cleared; data fields may hold.
  - stall=1 (no flush): every register holds its value.
  - Otherwise: capture all id_* fields and set ex_valid=id_valid.
  - When id_valid=0, load a bubble with controls cleared.
- Latency: one cycle from ID input to the ALU-facing outputs.
- Immediate: sign-extend id_imm to DW at capture time. ex_wr_reg is selected at capture.
- Forwarding is combinational from the registered rs/rt indices and values; the rt path works the same way as rs.
  - If exmem_reg_write, exmem_rd!=0 and exmem_rd==rs: use exmem_result.
  - Else if memwb_reg_write, memwb_rd!=0 and memwb_rd==rs: use memwb_result.
  - Else use the registered value.
  - EX/MEM always wins when both stages match.
  - Register 0 is never forwarded.
- Operand selection:
  - alu_operand1 = forwarded rs.
  - alu_operand2 = sign-extended imm if alu_src=1, else forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src.
- load_use_hazard = ex_valid & ex_mem_read & ex_wr_reg!=0 & (ex_wr_reg==id_rs | ex_wr_reg==id_rt).
  - Upstream responds by stalling IF/ID and asserting flush here for one cycle.
- Simultaneous stall and flush: flush wins.
- Reset mid-stall: the stage empties immediately.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding as specified above.
- Undefined:
  - Forwarding muxes are removed; the operands and ex_store_data use the registered register-file values only.
  - The exmem_*/memwb_* inputs stay on the port list but are ignored.
  - load_use_hazard is still generated.
  - Software or the hazard unit must cover RAW distance with stalls.

Decomposition:
- Shared package holds:
  - ALU op constants ALU_ADD=4'b0000, ALU_SUB=4'b0001, ALU_AND=4'b0010, ALU_OR=4'b0011.
  - DW and RW defaults.
  - Forward-select encoding: FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10.
- One natural sub-module, fwd_mux: computes one operand's select and value; instantiate it twice (rs and rt).

Test Plan:
- Reset asserted mid-run with ex_valid=1 -> ex_valid=0, ex_reg_write=0 and alu_control=0000 immediately, without waiting for a clock edge.
- Load rs_data=5, rt_data=3, alu_op=0001, alu_src=0, no forwarding matches -> next cycle alu_operand1=5, alu_operand2=3, alu_control=0001.
- alu_src=1, imm=16'hFFFE -> alu_operand2=32'hFFFFFFFE (-2).
- rs=8, exmem_rd=8 with exmem_result=100, memwb_rd=8 with memwb_result=200, both reg_write=1 -> alu_operand1=100.
  - Then set exmem_rd=0 -> alu_operand1=200.
  - Then set memwb_rd=0 -> registered value.
- EX holds lw with ex_wr_reg=9 and ex_valid=1; ID presents id_rt=9 -> load_use_hazard=1.
  - Then flush=1 for one cycle -> ex_valid=0 and hazard deasserts.
- stall=1 for 3 cycles while the ID inputs change -> outputs are unchanged.
  - Drive stall=1 and flush=1 together -> bubble is loaded.
